// File: rtl/dct_idct_seq_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the dct -> idct sequencer.
package dct_idct_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned BLK_N = 64;

  localparam int unsigned COEF_MSB = 31;
  localparam int unsigned COEF_LSB = 18;
  localparam int unsigned COEF_W   = COEF_MSB - COEF_LSB + 1;
  localparam int unsigned PIX_MSB  = 17;
  localparam int unsigned PIX_LSB  = 10;
  localparam int unsigned PIX_W    = PIX_MSB - PIX_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic in_window(input logic [31:0] cnt,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (cnt > lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/dct_idct_seq_ctrl_blk_window_gate.sv
// Passes the first BLK_N cycles of each done run as valid, then blocks until done drops.
module blk_window_gate #(
  parameter int unsigned BLK_N = dct_idct_pkg::BLK_N
) (
  input  logic clk,
  input  logic rst,
  input  logic done,
  output logic valid
);

  localparam int unsigned RW = $clog2(BLK_N + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(BLK_N);

  logic [RW-1:0] run;
  logic          armed;

  // armed stays low after reset until done is seen low, so a run cut by reset is never resumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run   <= '0;
      armed <= 1'b0;
    end else if (!done) begin
      run   <= '0;
      armed <= 1'b1;
    end else if (run != RUN_MAX) begin
      run <= run + 1'b1;
    end
  end

  assign valid = done & armed & (run < RUN_MAX);

endmodule

// File: rtl/dct_idct_seq_ctrl.sv
// Sequencer for the cascaded dct -> idct datapath: sample feed, drain, output windows,
// block counting and idct precision scheduling.
module dct_idct_seq_ctrl #(
  parameter int unsigned DW       = dct_idct_pkg::DW,
  parameter int unsigned BLK_N    = dct_idct_pkg::BLK_N,
  parameter int unsigned TOTAL_N  = 65536,
  parameter int unsigned DRAIN_N  = 16384,
  parameter int unsigned APX_LO   = 500000,
  parameter int unsigned APX_HI   = 1000000,
  parameter logic        RAPX_IN  = 1'b1,
  parameter logic        RAPX_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          src_ready,
  output logic          dct_start,
  output logic [DW-1:0] dct_din,
  input  logic          dct_reading,
  input  logic          dct_done,
  input  logic [DW-1:0] dct_dout,
  output logic          idct_start,
  output logic [DW-1:0] idct_din,
  output logic          idct_rapx,
  input  logic          idct_done,
  input  logic [DW-1:0] idct_dout,
  output logic          coef_valid,
  output logic [13:0]   coef_data,
  output logic          pix_valid,
  output logic [7:0]    pix_data,
  output logic [15:0]   blk_cnt,
  output logic          underrun,
  output logic          busy,
  output logic          finished
);

  import dct_idct_pkg::*;

  state_t      state;
  state_t      state_next;
  logic [31:0] samp_cnt;
  logic [31:0] drain_cnt;
  logic [31:0] cyc_cnt;
  logic [31:0] cyc_next;
  logic        start_hold;
  logic        done_q;
  logic        go_ok;
  logic        xfer;
  logic        last_xfer;
  logic        unused_bits;

  assign go_ok     = go & ((state == ST_IDLE) | (state == ST_DONE));
  assign xfer      = src_valid & src_ready;
  assign last_xfer = xfer & (samp_cnt == TOTAL_N - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // DRAIN leaves on the edge where drain_cnt reaches zero, so it spans DRAIN_N cycles
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (go_ok) state_next = ST_FEED;
      ST_FEED:  if (last_xfer) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt <= 32'd1) state_next = ST_DONE;
      ST_DONE:  if (go_ok) state_next = ST_FEED;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    src_ready = 1'b0;
    dct_start = 1'b0;
    busy      = 1'b0;
    finished  = 1'b0;
    unique case (state)
      ST_FEED: begin
        src_ready = dct_reading & (samp_cnt < TOTAL_N);
        dct_start = 1'b1;
        busy      = 1'b1;
      end
      ST_DRAIN: begin
        dct_start = start_hold & dct_reading;
        busy      = 1'b1;
      end
      ST_DONE: finished = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cyc_next = cyc_cnt;
    if (go_ok)                                   cyc_next = '0;
    else if ((state != ST_IDLE) && (cyc_cnt != '1)) cyc_next = cyc_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_cnt   <= '0;
      drain_cnt  <= '0;
      start_hold <= 1'b0;
      dct_din    <= '0;
      underrun   <= 1'b0;
      blk_cnt    <= '0;
      done_q     <= 1'b0;
      cyc_cnt    <= '0;
      idct_rapx  <= RAPX_OUT;
    end else begin
      if (go_ok)     samp_cnt <= '0;
      else if (xfer) samp_cnt <= samp_cnt + 32'd1;

      if (xfer) dct_din <= src_data;

      if (go_ok)                                            underrun <= 1'b0;
      else if ((state == ST_FEED) && dct_reading && !xfer) underrun <= 1'b1;

      if ((state == ST_FEED) && last_xfer) begin
        drain_cnt  <= DRAIN_N;
        start_hold <= 1'b1;
      end else if (state == ST_DRAIN) begin
        if (drain_cnt != '0) drain_cnt <= drain_cnt - 32'd1;
        if (!dct_reading)    start_hold <= 1'b0;
      end

      done_q <= dct_done;
      if (go_ok)                                              blk_cnt <= '0;
      else if (dct_done && !done_q && (state != ST_IDLE)) blk_cnt <= blk_cnt + 16'd1;

      cyc_cnt   <= cyc_next;
      idct_rapx <= in_window(cyc_next, APX_LO, APX_HI) ? RAPX_IN : RAPX_OUT;
    end
  end

  blk_window_gate #(.BLK_N(BLK_N)) u_coef_gate (
    .clk   (clk),
    .rst   (reset),
    .done  (dct_done),
    .valid (coef_valid)
  );

  blk_window_gate #(.BLK_N(BLK_N)) u_pix_gate (
    .clk   (clk),
    .rst   (reset),
    .done  (idct_done),
    .valid (pix_valid)
  );

  assign idct_start  = dct_done;
  assign coef_data   = dct_dout[COEF_MSB:COEF_LSB];
  assign idct_din    = {{(DW - COEF_W){dct_dout[COEF_MSB]}}, dct_dout[COEF_MSB:COEF_LSB]};
  assign pix_data    = idct_dout[PIX_MSB:PIX_LSB];
  assign unused_bits = ^{dct_dout[COEF_LSB-1:0], idct_dout[DW-1:PIX_MSB+1], idct_dout[PIX_LSB-1:0]};

endmodule

// File: tb/tb_dct_idct_seq_ctrl.sv
// Scoreboard bench for dct_idct_seq_ctrl with a shortened frame and a small rapx window.
module tb_dct_idct_seq_ctrl;

  localparam int unsigned TOTAL_N = 16;
  localparam int unsigned DRAIN_N = 8;
  localparam int unsigned APX_LO  = 20;
  localparam int unsigned APX_HI  = 40;
  localparam int unsigned BLK_N   = 64;

  logic        clk = 1'b0;
  logic        reset, go, src_valid, dct_reading, dct_done, idct_done;
  logic [31:0] src_data, dct_dout, idct_dout;
  logic        src_ready, dct_start, idct_start, idct_rapx;
  logic [31:0] dct_din, idct_din;
  logic        coef_valid, pix_valid, underrun, busy, finished;
  logic [13:0] coef_data;
  logic [7:0]  pix_data;
  logic [15:0] blk_cnt;

  always #5 clk = ~clk;

  dct_idct_seq_ctrl #(
    .DW(32), .BLK_N(BLK_N), .TOTAL_N(TOTAL_N), .DRAIN_N(DRAIN_N),
    .APX_LO(APX_LO), .APX_HI(APX_HI), .RAPX_IN(1'b0), .RAPX_OUT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .dct_start(dct_start), .dct_din(dct_din), .dct_reading(dct_reading),
    .dct_done(dct_done), .dct_dout(dct_dout),
    .idct_start(idct_start), .idct_din(idct_din), .idct_rapx(idct_rapx),
    .idct_done(idct_done), .idct_dout(idct_dout),
    .coef_valid(coef_valid), .coef_data(coef_data),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .blk_cnt(blk_cnt), .underrun(underrun), .busy(busy), .finished(finished)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] din_q[$];
  logic [45:0] coef_q[$];
  logic [7:0]  pix_q[$];
  logic [31:0] exp_din = '0;
  logic        din_chk = 1'b0;
  int          xfers   = 0;
  int          k_drain = -1;
  int          m_go    = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (m_go >= 0) m_go++;
  endtask

  // Monitor: samples every falling edge, pops expectations whenever the DUT presents data.
  always @(negedge clk) begin
    if (din_q.size() > 0) exp_din = din_q.pop_front();
    if (din_chk) check("dct_din", dct_din, exp_din);

    if (k_drain >= 0) begin
      k_drain++;
      // DRAIN spans DRAIN_N cycles after the accepting edge
      check("finished_timing", 32'(finished), 32'(k_drain == DRAIN_N + 1));
      if (k_drain > DRAIN_N) k_drain = -1;
    end
    if (src_valid && src_ready) begin
      din_q.push_back(src_data);
      xfers++;
      if (xfers == TOTAL_N) k_drain = 0;
    end

    if (m_go >= 0)
      check("idct_rapx", 32'(idct_rapx), (m_go > APX_LO && m_go < APX_HI) ? 32'd0 : 32'd1);

    check("idct_start", 32'(idct_start), 32'(dct_done));

    if (coef_valid) begin
      if (coef_q.size() == 0) check("coef_valid_extra", 32'(coef_valid), 32'd0);
      else begin
        logic [45:0] e;
        e = coef_q.pop_front();
        check("coef_data", 32'(coef_data), 32'(e[45:32]));
        check("idct_din", idct_din, e[31:0]);
      end
    end
    if (pix_valid) begin
      if (pix_q.size() == 0) check("pix_valid_extra", 32'(pix_valid), 32'd0);
      else check("pix_data", 32'(pix_data), 32'(pix_q.pop_front()));
    end
  end

  task automatic run_windows(input logic [31:0] dd, input logic [13:0] ec, input logic [31:0] ei,
                             input int dlen, input logic [31:0] id, input logic [7:0] ep,
                             input int ilen);
    int n;
    n = (dlen > ilen) ? dlen : ilen;
    for (int c = 0; c < n; c++) begin
      dct_done  = (c < dlen);
      dct_dout  = dd;
      idct_done = (c < ilen);
      idct_dout = id;
      if (c < dlen && c < BLK_N) coef_q.push_back({ec, ei});
      if (c < ilen && c < BLK_N) pix_q.push_back(ep);
      step();
    end
    dct_done  = 1'b0;
    idct_done = 1'b0;
    step();
    step();
    check("coef_window_len", 32'(coef_q.size()), 32'd0);
    check("pix_window_len", 32'(pix_q.size()), 32'd0);
  endtask

  task automatic feed_to_finish(input logic [31:0] base);
    int xb;
    int dn;
    dn = 0;
    for (int i = 0; i < 200; i++) begin
      xb = xfers;
      src_data = base + 32'(i);
      if (xb >= TOTAL_N) dn++;
      dct_reading = (dn != 3);
      @(negedge clk);
      if (finished) break;
      if (xb < TOTAL_N) begin
        check("src_ready_feed", 32'(src_ready), 32'd1);
        check("dct_start_feed", 32'(dct_start), 32'd1);
      end else begin
        check("src_ready_drain", 32'(src_ready), 32'd0);
        check("dct_start_drain", 32'(dct_start), 32'(dn < 3));
        check("busy_drain", 32'(busy), 32'd1);
      end
      step();
    end
    check("run_finished", 32'(finished), 32'd1);
    check("xfer_total", 32'(xfers), TOTAL_N);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; go = 1'b0; src_valid = 1'b0; src_data = '0; dct_reading = 1'b0;
    dct_done = 1'b0; dct_dout = '0; idct_done = 1'b0; idct_dout = '0;
    step();
    step();
    @(negedge clk);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_dct_start", 32'(dct_start), 32'd0);
    check("rst_dct_din", dct_din, 32'd0);
    check("rst_coef_valid", 32'(coef_valid), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_idct_rapx", 32'(idct_rapx), 32'd1);
    step();
    reset = 1'b0;
    step();

    // Run 1: source always valid, dct always reading; one reading gap during DRAIN.
    go = 1'b1;
    step();
    go = 1'b0; m_go = 0; din_chk = 1'b1; src_valid = 1'b1; dct_reading = 1'b1;
    feed_to_finish(32'hA500_0000);
    check("run1_underrun", 32'(underrun), 32'd0);

    run_windows(32'h8004_0000, 14'h2001, 32'hFFFF_E001, 100, 32'h0003_FC00, 8'hFF, 70);
    check("blk_cnt_one", 32'(blk_cnt), 32'd1);
    run_windows(32'h7FFC_0000, 14'h1FFF, 32'h0000_1FFF, 64, 32'h0001_4800, 8'h52, 65);
    check("blk_cnt_two", 32'(blk_cnt), 32'd2);

    // Run 2 from DONE: starved source then last transfer with reading falling.
    src_valid = 1'b0;
    xfers = 0;
    go = 1'b1;
    step();
    go = 1'b0; m_go = 0;
    @(negedge clk);
    check("go2_busy", 32'(busy), 32'd1);
    check("go2_finished", 32'(finished), 32'd0);
    check("go2_blk_cnt", 32'(blk_cnt), 32'd0);
    check("go2_underrun", 32'(underrun), 32'd0);
    step();
    @(negedge clk);
    check("underrun_set", 32'(underrun), 32'd1);
    check("src_ready_starved", 32'(src_ready), 32'd1);
    step();
    src_valid = 1'b1;
    for (int i = 0; i < TOTAL_N; i++) begin
      src_data = 32'hB600_0000 + 32'(i);
      step();
    end
    dct_reading = 1'b0;
    @(negedge clk);
    check("simul_dct_start", 32'(dct_start), 32'd0);
    check("simul_busy", 32'(busy), 32'd1);
    check("simul_src_ready", 32'(src_ready), 32'd0);
    step();
    dct_reading = 1'b1;
    @(negedge clk);
    check("start_stays_low", 32'(dct_start), 32'd0);
    for (int i = 0; i < 50 && !finished; i++) step();
    check("run2_finished", 32'(finished), 32'd1);
    check("run2_underrun_sticky", 32'(underrun), 32'd1);
    check("run2_xfers", 32'(xfers), TOTAL_N);
    step();

    // Run 3: reset lands mid-FEED and mid-coefficient-window.
    xfers = 0;
    go = 1'b1;
    step();
    go = 1'b0; m_go = 0;
    for (int c = 0; c < 10; c++) begin
      src_data = 32'hC700_0000 + 32'(c);
      dct_done = 1'b1;
      dct_dout = 32'h8004_0000;
      coef_q.push_back({14'h2001, 32'hFFFF_E001});
      step();
    end
    reset = 1'b1; m_go = -1; din_chk = 1'b0;
    @(negedge clk);
    check("midrst_coef_valid", 32'(coef_valid), 32'd0);
    check("midrst_src_ready", 32'(src_ready), 32'd0);
    check("midrst_dct_start", 32'(dct_start), 32'd0);
    check("midrst_dct_din", dct_din, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_blk_cnt", 32'(blk_cnt), 32'd0);
    check("midrst_rapx", 32'(idct_rapx), 32'd1);
    check("midrst_coef_popped", 32'(coef_q.size()), 32'd0);
    din_q.delete();
    exp_din = '0;
    xfers = 0;
    step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) step();
    @(negedge clk);
    check("no_partial_window", 32'(coef_valid), 32'd0);
    step();
    dct_done = 1'b0;
    step();
    @(negedge clk);
    check("idle_blk_cnt", 32'(blk_cnt), 32'd0);
    step();

    go = 1'b1;
    step();
    go = 1'b0; m_go = 0; din_chk = 1'b1;
    feed_to_finish(32'hD800_0000);
    check("run3_underrun", 32'(underrun), 32'd0);
    run_windows(32'h8004_0000, 14'h2001, 32'hFFFF_E001, 64, 32'h0003_FC00, 8'hFF, 64);
    check("run3_blk_cnt", 32'(blk_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
